// File: rtl/generador_frecuencia.sv
// BCD-programmed 50% square-wave generator: load->commit takes 4+DIV_W cycles (5 for f=0); cargar is ignored while ocupado.
// Define GENFREC_PULSO_EN to generate the one-cycle pulso strobe on each rising edge of salida.
module generador_frecuencia #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIV_W  = 26
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  miles,
    input  logic [3:0]  centenas,
    input  logic [3:0]  decenas,
    input  logic [3:0]  unidades,
    input  logic        cargar,
    output logic        salida,
    output logic        ocupado,
    output logic [13:0] frecuencia,
    output logic        error,
    output logic        pulso
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_DIVIDE  = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    localparam int               CNT_W   = $clog2(DIV_W) + 1;
    localparam logic [DIV_W-1:0] HALF_HZ = DIV_W'(CLK_HZ / 2);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [15:0]      hold_q, hold_d;
    logic [13:0]      acc_q, acc_d;
    logic [13:0]      rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [13:0]      frec_q, frec_d;
    logic             salida_q, salida_d;
    logic             error_q, error_d;
    logic             run_q, run_d;

    logic             digit_bad;
    logic [3:0]       digit;
    logic [14:0]      rem_sh;
    logic             div_ge;
    logic [13:0]      rem_sub;
    logic [DIV_W-1:0] quo_n;

    assign digit_bad = (miles > 4'd9) || (centenas > 4'd9) ||
                       (decenas > 4'd9) || (unidades > 4'd9);

    always_comb begin
        digit = hold_q[3:0];
        case (step_q[1:0])
            2'd0:    digit = hold_q[15:12];
            2'd1:    digit = hold_q[11:8];
            2'd2:    digit = hold_q[7:4];
            default: digit = hold_q[3:0];
        endcase
    end

    // Restoring division: dividend bits shift out of quo_q MSB-first while quotient bits shift in.
    assign rem_sh  = {rem_q, quo_q[DIV_W-1]};
    assign div_ge  = rem_sh >= {1'b0, acc_q};
    assign rem_sub = 14'(rem_sh - {1'b0, acc_q});
    assign quo_n   = {quo_q[DIV_W-2:0], div_ge};

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        hold_d   = hold_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        half_d   = half_q;
        cnt_d    = cnt_q;
        frec_d   = frec_q;
        salida_d = salida_q;
        error_d  = error_q;
        run_d    = run_q;

        // The current waveform keeps running while a new setting is being computed.
        if (run_q) begin
            if (cnt_q == half_q - DIV_W'(1)) begin
                cnt_d    = '0;
                salida_d = ~salida_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        case (state_q)
            S_CONVERT: begin
                acc_d  = 14'(acc_q * 14'd10) + {10'd0, digit};
                step_d = step_q + CNT_W'(1);
                if (step_q == CNT_W'(3)) begin
                    step_d  = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (acc_q == 14'd0) begin
                    frec_d   = '0;
                    salida_d = 1'b0;
                    cnt_d    = '0;
                    run_d    = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    rem_d  = div_ge ? rem_sub : rem_sh[13:0];
                    quo_d  = quo_n;
                    step_d = step_q + CNT_W'(1);
                    if (step_q == CNT_W'(DIV_W - 1)) begin
                        half_d   = (quo_n == '0) ? DIV_W'(1) : quo_n;
                        frec_d   = acc_q;
                        cnt_d    = '0;
                        salida_d = 1'b0;
                        run_d    = 1'b1;
                        step_d   = '0;
                        state_d  = S_RUN;
                    end
                end
            end
            default: begin
                if (cargar) begin
                    if (digit_bad) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        hold_d  = {miles, centenas, decenas, unidades};
                        acc_d   = '0;
                        rem_d   = '0;
                        quo_d   = HALF_HZ;
                        step_d  = '0;
                        state_d = S_CONVERT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            hold_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            half_q   <= '0;
            cnt_q    <= '0;
            frec_q   <= '0;
            salida_q <= 1'b0;
            error_q  <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            frec_q   <= frec_d;
            salida_q <= salida_d;
            error_q  <= error_d;
            run_q    <= run_d;
        end
    end

    assign salida     = salida_q;
    assign ocupado    = (state_q == S_CONVERT) || (state_q == S_DIVIDE);
    assign frecuencia = frec_q;
    assign error      = error_q;

`ifdef GENFREC_PULSO_EN
    logic salida_prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            salida_prev_q <= 1'b0;
        end else begin
            salida_prev_q <= salida_q;
        end
    end

    assign pulso = salida_q & ~salida_prev_q;
`else
    assign pulso = 1'b0;
`endif

endmodule

// File: tb/tb_generador_frecuencia.sv
// Scoreboard bench for generador_frecuencia at CLK_HZ=1000, DIV_W=10 (dividend 500).
module tb_generador_frecuencia;

    localparam int CLK_HZ = 1000;
    localparam int DIV_W  = 10;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  miles = '0, centenas = '0, decenas = '0, unidades = '0;
    logic        cargar = 1'b0;
    logic        salida, ocupado, error, pulso;
    logic [13:0] frecuencia;

    generador_frecuencia #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .miles(miles), .centenas(centenas), .decenas(decenas), .unidades(unidades),
        .cargar(cargar), .salida(salida), .ocupado(ocupado),
        .frecuencia(frecuencia), .error(error), .pulso(pulso)
    );

    always #5 clock = ~clock;

    typedef struct {
        int freq;
        int half;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: commits are the falling edge of ocupado; toggles are timed against the committed half period.
    int   run_len     = 0;
    int   active_half = 0;
    int   busy_cnt    = 0;
    logic prev_sal    = 1'b0;
    logic prev_ocu    = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            run_len     = 0;
            active_half = 0;
            busy_cnt    = 0;
            prev_sal    = 1'b0;
            prev_ocu    = 1'b0;
        end else begin
`ifdef GENFREC_PULSO_EN
            if ((salida && !prev_sal) || pulso)
                check("pulso", int'(pulso), int'(salida && !prev_sal));
`else
            if ((salida && !prev_sal) || pulso)
                check("pulso_off", int'(pulso), 0);
`endif
            if (ocupado) busy_cnt++;
            if (prev_ocu && !ocupado) begin
                check("commit_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("busy_cycles", busy_cnt, mon_e.busy);
                    check("frecuencia", int'(frecuencia), mon_e.freq);
                    check("salida_at_commit", int'(salida), 0);
                    active_half = mon_e.half;
                end
                busy_cnt = 0;
                run_len  = 0;
            end else begin
                run_len++;
                if (salida != prev_sal) begin
                    if (active_half == 0)
                        check("idle_salida", int'(salida), int'(prev_sal));
                    else
                        check("half_period", run_len, active_half);
                    run_len = 0;
                end else if (active_half > 0 && run_len > active_half) begin
                    check("half_period_overrun", run_len, active_half);
                    run_len = 0;
                end
            end
            prev_sal = salida;
            prev_ocu = ocupado;
        end
    end

    // Called at a negedge; cargar is sampled on the next posedge and the task returns at the following negedge.
    task automatic do_load(input logic [3:0] m, input logic [3:0] c, input logic [3:0] d,
                           input logic [3:0] u, input int f, input int half, input int busy,
                           input bit push);
        miles = m; centenas = c; decenas = d; unidades = u;
        cargar = 1'b1;
        if (push) exp_q.push_back('{f, half, busy});
        @(negedge clock);
        cargar = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || ocupado) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("commit_within_budget", exp_q.size(), 0);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_salida", int'(salida), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_frecuencia", int'(frecuencia), 0);
        check("rst_error", int'(error), 0);
        check("rst_pulso", int'(pulso), 0);
        #2 reset_n = 1'b1;
        @(negedge clock);

        // 1 Hz: half = 500
        do_load(4'd0, 4'd0, 4'd0, 4'd1, 1, 500, 14, 1'b1);
        check("err_0001", int'(error), 0);
        check("busy_after_load", int'(ocupado), 1);
        wait_idle(40);
        run(1100);

        // 250 Hz (half 2), then 300 Hz (half 1) while the old wave keeps running
        do_load(4'd0, 4'd2, 4'd5, 4'd0, 250, 2, 14, 1'b1);
        wait_idle(40);
        run(20);
        do_load(4'd0, 4'd3, 4'd0, 4'd0, 300, 1, 14, 1'b1);
        wait_idle(40);
        run(10);

        // 9999 Hz clamps half to 1; back-to-back load right after commit
        do_load(4'd9, 4'd9, 4'd9, 4'd9, 9999, 1, 14, 1'b1);
        wait_idle(40);
        do_load(4'd0, 4'd2, 4'd5, 4'd0, 250, 2, 14, 1'b1);
        wait_idle(40);
        run(12);

        // 0 Hz stops the wave
        do_load(4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 5, 1'b1);
        wait_idle(40);
        run(20);
        check("zero_salida", int'(salida), 0);
        check("zero_frecuencia", int'(frecuencia), 0);

        // Bad digit: error set, nothing else changes
        do_load(4'd0, 4'd0, 4'hA, 4'd0, 0, 0, 0, 1'b0);
        check("err_set", int'(error), 1);
        run(3);
        check("err_no_busy", int'(ocupado), 0);
        check("err_frecuencia", int'(frecuencia), 0);

        do_load(4'd0, 4'd0, 4'd0, 4'd5, 5, 100, 14, 1'b1);
        check("err_clear", int'(error), 0);
        wait_idle(40);
        run(250);

        // Bad digit while running at 5 Hz
        do_load(4'hB, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1'b0);
        check("err_set_run", int'(error), 1);
        run(5);
        check("err_run_frecuencia", int'(frecuencia), 5);
        check("err_run_busy", int'(ocupado), 0);

        // Loads at +3 and +8 cycles are ignored
        do_load(4'd0, 4'd2, 4'd5, 4'd0, 250, 2, 14, 1'b1);
        check("busy_err_clear", int'(error), 0);
        run(2);
        do_load(4'd0, 4'd0, 4'd0, 4'd7, 0, 0, 0, 1'b0);
        check("ignored_err", int'(error), 0);
        run(4);
        do_load(4'd0, 4'd0, 4'hA, 4'd7, 0, 0, 0, 1'b0);
        check("ignored_bad_err", int'(error), 0);
        wait_idle(40);
        run(12);
        check("single_commit_freq", int'(frecuencia), 250);

        // Reset mid-DIVIDE
        do_load(4'd0, 4'd1, 4'd0, 4'd0, 100, 5, 14, 1'b1);
        run(7);
        check("mid_divide_busy", int'(ocupado), 1);
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_salida", int'(salida), 0);
        check("arst_ocupado", int'(ocupado), 0);
        check("arst_frecuencia", int'(frecuencia), 0);
        check("arst_error", int'(error), 0);
        check("arst_pulso", int'(pulso), 0);
        run(2);
        #2 reset_n = 1'b1;
        run(60);
        check("post_rst_salida", int'(salida), 0);
        check("post_rst_frecuencia", int'(frecuencia), 0);
        check("post_rst_ocupado", int'(ocupado), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
